// File: rtl/th_disp_pkg.sv
// Shared constants for the DHT11 display formatter: FSM encoding, dash code,
// 7-segment table and the double-dabble helpers.
package th_disp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADJ,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam logic [3:0] DASH      = 4'hA;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp, g..a}, indexed by nibble; A is a lone g-segment dash.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [11:0] adj3(input logic [11:0] s);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
    end
    return r;
  endfunction

  // A value above 99 cannot be shown on two digits, so it becomes two dashes.
  function automatic logic [7:0] fmt_byte(input logic [11:0] s);
    return (s[11:8] != 4'd0) ? {DASH, DASH} : s[7:0];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low 7-segment decoder with a blank override.
module seg7_decode
  import th_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] seg
);

  assign seg = blank ? SEG_BLANK : SEG_LUT[nibble];

endmodule

// File: rtl/th_display_fmt.sv
// DHT11 temperature/humidity to BCD converter with 4-digit multiplexed display.
// Optional macro TH_LEADING_ZERO_BLANK_EN blanks a zero tens digit on the display.
module th_display_fmt
  import th_disp_pkg::*;
#(
  parameter int CLK_HZ  = 27_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] th_in,
  output logic [15:0] bcd,
  output logic        busy,
  output logic [7:0]  seg,
  output logic [3:0]  dig_sel
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] th_q, th_d;
  logic [15:0] snap_q, snap_d;
  logic [11:0] t_scr_q, t_scr_d;
  logic [11:0] h_scr_q, h_scr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] bcd_q, bcd_d;
  logic        busy_q, busy_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]  idx_q, idx_d;
  logic        scan_on_q, scan_on_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  dig_sel_q, dig_sel_d;

  logic [2:0]  bit_sel;
  logic [3:0]  nib;
  logic        blank;
  logic [7:0]  seg_dec;

  // Conversion FSM: double-dabble both bytes in parallel from the snapshot.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    th_d    = th_in;
    snap_d  = snap_q;
    t_scr_d = t_scr_q;
    h_scr_d = h_scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bit_sel = ~cnt_q;
    unique case (state_q)
      S_IDLE: if (th_q != snap_q) state_d = S_LOAD;
      S_LOAD: begin
        snap_d  = th_q;
        t_scr_d = '0;
        h_scr_d = '0;
        cnt_d   = '0;
        state_d = S_ADJ;
      end
      S_ADJ: begin
        t_scr_d = adj3(t_scr_q);
        h_scr_d = adj3(h_scr_q);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        t_scr_d = {t_scr_q[10:0], snap_q[{1'b1, bit_sel}]};
        h_scr_d = {h_scr_q[10:0], snap_q[{1'b0, bit_sel}]};
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = S_ADJ;
        end
      end
      S_DONE: begin
        bcd_d   = {fmt_byte(t_scr_q), fmt_byte(h_scr_q)};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Held through the cycle that writes bcd, so it falls once the result is visible.
    busy_d = (state_q != S_IDLE) || (state_d != S_IDLE);
  end

  // Scanner: index advances on each prescaler wrap; digits stay dark until the first wrap.
  always_comb begin
    pre_d     = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    scan_on_d = scan_on_q;
    idx_d     = idx_q;
    if (pre_q == PRE_LAST) begin
      scan_on_d = 1'b1;
      if (scan_on_q) idx_d = idx_q + 2'd1;
    end
    unique case (idx_d)
      2'd0:    nib = bcd_q[3:0];
      2'd1:    nib = bcd_q[7:4];
      2'd2:    nib = bcd_q[11:8];
      default: nib = bcd_q[15:12];
    endcase
`ifdef TH_LEADING_ZERO_BLANK_EN
    blank = idx_d[0] && (nib == 4'd0);
`else
    blank = 1'b0;
`endif
    dig_sel_d = scan_on_d ? ~(4'b0001 << idx_d) : 4'hF;
    seg_d     = scan_on_d ? seg_dec : SEG_BLANK;
  end

  seg7_decode u_seg7_decode (
    .nibble(nib),
    .blank (blank),
    .seg   (seg_dec)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      th_q      <= '0;
      snap_q    <= '0;
      t_scr_q   <= '0;
      h_scr_q   <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      pre_q     <= '0;
      idx_q     <= '0;
      scan_on_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      dig_sel_q <= 4'hF;
    end else begin
      state_q   <= state_d;
      th_q      <= th_d;
      snap_q    <= snap_d;
      t_scr_q   <= t_scr_d;
      h_scr_q   <= h_scr_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      scan_on_q <= scan_on_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign bcd     = bcd_q;
  assign busy    = busy_q;
  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_th_display_fmt.sv
// Self-checking bench for th_display_fmt: bcd results go through a scoreboard
// queue checked by a monitor on every bcd change; scan and reset are checked inline.
`timescale 1ns/1ps
module tb_th_display_fmt;

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;

`ifdef TH_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] TENS0_SEG = 8'hFF;
`else
  localparam logic [7:0] TENS0_SEG = 8'hC0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] th_in;
  logic [15:0] bcd;
  logic        busy;
  logic [7:0]  seg;
  logic [3:0]  dig_sel;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  th_display_fmt #(.CLK_HZ(1000), .SCAN_HZ(100)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .th_in  (th_in),
    .bcd    (bcd),
    .busy   (busy),
    .seg    (seg),
    .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every bcd change outside reset must match the next expected result and cycle.
  initial begin
    logic [15:0] prev;
    exp_t e;
    prev = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = bcd;
      end else if (bcd !== prev) begin
        if (sb.size() == 0) begin
          check("bcd_spurious", {16'h0, bcd}, {16'h0, prev});
        end else begin
          e = sb.pop_front();
          check("bcd_value", {16'h0, bcd}, {16'h0, e.val});
          check("bcd_cycle", cyc, e.cyc);
        end
        prev = bcd;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] v, output int c);
    @(posedge clk);
    #1;
    th_in = v;
    c = cyc;
  endtask

  task automatic scan_check();
    logic [3:0] dseq [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    logic [7:0] sseq [5] = '{8'h92, TENS0_SEG, 8'hBF, 8'hBF, 8'h92};
    logic [3:0] prev;
    int n;
    int t;
    prev = dig_sel;
    n = 0;
    do begin
      prev = dig_sel;
      @(negedge clk);
      n++;
    end while (!(dig_sel == 4'hE && prev != 4'hE) && n < 60);
    check("scan_dig0", {28'h0, dig_sel}, {28'h0, dseq[0]});
    check("scan_seg0", {24'h0, seg}, {24'h0, sseq[0]});
    t = cyc;
    for (int i = 1; i < 5; i++) begin
      prev = dig_sel;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (dig_sel == prev && n < 30);
      check($sformatf("scan_dig%0d", i), {28'h0, dig_sel}, {28'h0, dseq[i]});
      check($sformatf("scan_seg%0d", i), {24'h0, seg}, {24'h0, sseq[i]});
      check($sformatf("scan_period%0d", i), cyc - t, 10);
      t = cyc;
    end
  endtask

  initial begin
    int c;
    int nb;
    rst_n = 1'b0;
    th_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_bcd", {16'h0, bcd}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_seg", {24'h0, seg}, 32'hFF);
    check("rst_dig_sel", {28'h0, dig_sel}, 32'hF);

    // 25 C / 65 % with exact latency and busy width
    drive(16'h1941, c);
    sb.push_back('{16'h2565, c + 20});
    nb = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("busy_cycles", nb, 19);
    wait_drain(40);

    // 100 C saturates to dashes, humidity 5 has a zero tens digit
    drive(16'h6405, c);
    sb.push_back('{16'hAA05, c + 20});
    wait_drain(40);
    scan_check();

    // input changes at conversion cycle 6: first result stands, then reconvert
    drive(16'h1941, c);
    sb.push_back('{16'h2565, c + 20});
    repeat (6) @(posedge clk);
    #1 th_in = 16'h1A40;
    sb.push_back('{16'h2664, c + 39});
    wait_drain(80);

    // reset at conversion cycle 8 discards the work; reconversion after release
    drive(16'h0C22, c);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_bcd", {16'h0, bcd}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_seg", {24'h0, seg}, 32'hFF);
    check("midrst_dig_sel", {28'h0, dig_sel}, 32'hF);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    c = cyc;
    sb.push_back('{16'h1234, c + 20});
    repeat (3) @(negedge clk);
    check("post_rst_dig_sel", {28'h0, dig_sel}, 32'hF);
    check("post_rst_seg", {24'h0, seg}, 32'hFF);
    wait_drain(40);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
